// File: rtl/fu_alu_ctrl.sv
// fu_alu_ctrl: ALU issue/writeback controller with a two-stage E/W pipeline.
//
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   issue_valid / issue_ready      dispatch handshake
//   issue_aluop, issue_a, issue_b  micro-op fields from dispatch
//   issue_imm, issue_imm_sel       immediate operand and its select for B
//   issue_tag                      destination tag carried down the pipe
//   flush                          synchronous squash of every in-flight op
//   aluop, port_a, port_b          ALU operands, driven straight from E
//   port_output, negative,
//   overflow, zero                 ALU result and flags, captured into W
//   wb_valid / wb_ready            writeback handshake
//   wb_result, wb_flags, wb_tag    writeback payload, flags = {N, V, Z}
//   busy                           E or W holds a valid op
//   ops_retired                    wrapping count of writeback handshakes
module fu_alu_ctrl #(
    parameter int TAG_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [3:0]       issue_aluop,
    input  logic [31:0]      issue_a,
    input  logic [31:0]      issue_b,
    input  logic [31:0]      issue_imm,
    input  logic             issue_imm_sel,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic             flush,
    output logic [3:0]       aluop,
    output logic [31:0]      port_a,
    output logic [31:0]      port_b,
    input  logic [31:0]      port_output,
    input  logic             negative,
    input  logic             overflow,
    input  logic             zero,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_result,
    output logic [2:0]       wb_flags,
    output logic [TAG_W-1:0] wb_tag,
    output logic             busy,
    output logic [CNT_W-1:0] ops_retired
);

    logic             e_valid;
    logic             w_valid;
    logic [TAG_W-1:0] e_tag;
    logic             w_adv;
    logic             e_adv;
    logic             fire;

    // E only ever moves into W, so both stages advance together; a stalled W
    // freezes the whole pipe while an empty or draining W lets it flow.
    assign w_adv       = !w_valid || wb_ready;
    assign e_adv       = w_adv;
    assign issue_ready = !e_valid || e_adv;
    assign fire        = issue_valid && issue_ready && !flush;
    assign wb_valid    = w_valid;
    assign busy        = e_valid || w_valid;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            e_valid     <= 1'b0;
            w_valid     <= 1'b0;
            e_tag       <= '0;
            aluop       <= '0;
            port_a      <= '0;
            port_b      <= '0;
            wb_result   <= '0;
            wb_flags    <= '0;
            wb_tag      <= '0;
            ops_retired <= '0;
        end else begin
            e_valid <= flush ? 1'b0 : fire ? 1'b1 : e_adv ? 1'b0 : e_valid;
            w_valid <= flush ? 1'b0 : w_adv ? e_valid : w_valid;
            if (fire) begin
                aluop  <= issue_aluop;
                port_a <= issue_a;
                port_b <= issue_imm_sel ? issue_imm : issue_b;
                e_tag  <= issue_tag;
            end
            // Payload may load stale data during a flush; only w_valid matters.
            if (w_adv) begin
                wb_result <= port_output;
                wb_flags  <= {negative, overflow, zero};
                wb_tag    <= e_tag;
            end
            // A handshake in a flush cycle has already completed, so it counts.
            if (w_valid && wb_ready)
                ops_retired <= ops_retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_fu_alu_ctrl.sv
// tb_fu_alu_ctrl: directed vector bench for fu_alu_ctrl with a small ALU model.
module tb_fu_alu_ctrl;

    localparam int TAG_W = 6;
    localparam int CNT_W = 4;
    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             issue_valid, issue_ready, issue_imm_sel, flush;
    logic [3:0]       issue_aluop, aluop;
    logic [31:0]      issue_a, issue_b, issue_imm, port_a, port_b, port_output, wb_result;
    logic [TAG_W-1:0] issue_tag, wb_tag;
    logic             negative, overflow, zero, wb_valid, wb_ready, busy;
    logic [2:0]       wb_flags;
    logic [CNT_W-1:0] ops_retired;

    int n_cmp = 0;
    int n_err = 0;
    logic [CNT_W-1:0] exp_cnt;

    fu_alu_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_aluop(issue_aluop), .issue_a(issue_a), .issue_b(issue_b),
        .issue_imm(issue_imm), .issue_imm_sel(issue_imm_sel), .issue_tag(issue_tag),
        .flush(flush),
        .aluop(aluop), .port_a(port_a), .port_b(port_b),
        .port_output(port_output), .negative(negative), .overflow(overflow), .zero(zero),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_result(wb_result), .wb_flags(wb_flags), .wb_tag(wb_tag),
        .busy(busy), .ops_retired(ops_retired)
    );

    always #5 CLK = ~CLK;

    // Reference ALU: ADD/SUB with signed overflow.
    always_comb begin
        port_output = (aluop == SUB) ? port_a - port_b : port_a + port_b;
        overflow    = (aluop == SUB)
                    ? (port_a[31] != port_b[31]) && (port_output[31] != port_a[31])
                    : (port_a[31] == port_b[31]) && (port_output[31] != port_a[31]);
        negative    = port_output[31];
        zero        = (port_output == 32'd0);
    end

    typedef struct {
        logic [3:0]       op;
        logic [31:0]      a, b, imm;
        logic             sel;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp_b, exp_res;
        logic [2:0]       exp_flags;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic sel, input logic [TAG_W-1:0] tag);
        issue_valid   = 1'b1;
        issue_aluop   = op;
        issue_a       = a;
        issue_b       = b;
        issue_imm     = imm;
        issue_imm_sel = sel;
        issue_tag     = tag;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{ADD, 32'h7FFFFFFF, 32'h1,        32'h0,        1'b0, 6'd5, 32'h1,        32'h80000000, 3'b110};
        vecs[1] = '{SUB, 32'hFFFFFFFF, 32'h10,       32'hFFFFFFFF, 1'b1, 6'd6, 32'hFFFFFFFF, 32'h0,        3'b001};
        vecs[2] = '{ADD, 32'h5,        32'h3,        32'h0,        1'b0, 6'd2, 32'h3,        32'h8,        3'b000};
        vecs[3] = '{SUB, 32'h3,        32'h5,        32'h0,        1'b0, 6'd3, 32'h5,        32'hFFFFFFFE, 3'b100};
        vecs[4] = '{ADD, 32'h80000000, 32'h0,        32'h80000000, 1'b1, 6'd7, 32'h80000000, 32'h0,        3'b011};
        vecs[5] = '{SUB, 32'h80000000, 32'h1,        32'h99,       1'b0, 6'd9, 32'h1,        32'h7FFFFFFF, 3'b010};

        nRST = 1'b0;
        issue_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
        issue_aluop = '0; issue_a = '0; issue_b = '0; issue_imm = '0; issue_imm_sel = 1'b0; issue_tag = '0;
        #3;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_port_a", port_a, 0);
        chk("rst_wb_result", wb_result, 0);
        chk("rst_ops_retired", ops_retired, 0);
        tick;
        nRST = 1'b1;
        exp_cnt = '0;

        // Single ops, one at a time
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].sel, vecs[i].tag);
            tick;
            chk("vec_aluop", aluop, vecs[i].op);
            chk("vec_port_a", port_a, vecs[i].a);
            chk("vec_port_b", port_b, vecs[i].exp_b);
            issue_valid = 1'b0;
            tick;
            chk("vec_wb_valid", wb_valid, 1);
            chk("vec_wb_result", wb_result, vecs[i].exp_res);
            chk("vec_wb_flags", wb_flags, vecs[i].exp_flags);
            chk("vec_wb_tag", wb_tag, vecs[i].tag);
            tick;
            exp_cnt++;
            chk("vec_ops_retired", ops_retired, exp_cnt);
            chk("vec_wb_empty", wb_valid, 0);
        end

        // Streaming 8 back-to-back ops
        for (int c = 0; c < 10; c++) begin
            chk("stream_issue_ready", issue_ready, 1);
            if (c < 8) issue(ADD, c, 0, 0, 1'b0, c[TAG_W-1:0]);
            else issue_valid = 1'b0;
            tick;
            chk("stream_wb_valid", wb_valid, (c >= 1 && c <= 8) ? 1 : 0);
            if (c >= 1 && c <= 8) chk("stream_wb_tag", wb_tag, c - 1);
        end
        exp_cnt = exp_cnt + 4'd8;
        chk("stream_ops_retired", ops_retired, exp_cnt);

        // Backpressure
        wb_ready = 1'b0;
        issue(ADD, 32'd10, 32'd0, 0, 1'b0, 6'd10);
        tick;
        chk("bp_ready_1", issue_ready, 1);
        issue(ADD, 32'd11, 32'd0, 0, 1'b0, 6'd11);
        tick;
        issue(ADD, 32'd12, 32'd0, 0, 1'b0, 6'd12);
        for (int c = 0; c < 3; c++) begin
            chk("bp_ready_low", issue_ready, 0);
            chk("bp_wb_valid", wb_valid, 1);
            chk("bp_wb_tag", wb_tag, 10);
            chk("bp_wb_result", wb_result, 10);
            chk("bp_port_a", port_a, 11);
            if (c < 2) tick;
        end
        wb_ready = 1'b1;
        #1;
        chk("bp_release_ready", issue_ready, 1);
        tick;
        issue_valid = 1'b0;
        exp_cnt++;
        chk("bp_drain_tag_11", wb_tag, 11);
        chk("bp_drain_res_11", wb_result, 11);
        tick;
        exp_cnt++;
        chk("bp_drain_valid_12", wb_valid, 1);
        chk("bp_drain_tag_12", wb_tag, 12);
        tick;
        exp_cnt++;
        chk("bp_drain_empty", wb_valid, 0);
        chk("bp_ops_retired", ops_retired, exp_cnt);

        // Flush with both stages full, no handshake
        wb_ready = 1'b0;
        issue(ADD, 32'd20, 0, 0, 1'b0, 6'd20);
        tick;
        issue(ADD, 32'd21, 0, 0, 1'b0, 6'd21);
        tick;
        chk("fl_busy_before", busy, 1);
        issue(ADD, 32'd22, 0, 0, 1'b0, 6'd22);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        issue_valid = 1'b0;
        chk("fl_busy", busy, 0);
        chk("fl_wb_valid", wb_valid, 0);
        chk("fl_ops_retired", ops_retired, exp_cnt);
        wb_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("fl_no_ghost", wb_valid, 0);
        end

        // Flush while a handshake completes in the same cycle
        wb_ready = 1'b0;
        issue(ADD, 32'd23, 0, 0, 1'b0, 6'd23);
        tick;
        issue(ADD, 32'd24, 0, 0, 1'b0, 6'd24);
        tick;
        issue_valid = 1'b0;
        flush = 1'b1;
        wb_ready = 1'b1;
        tick;
        flush = 1'b0;
        exp_cnt++;
        chk("flhs_ops_retired", ops_retired, exp_cnt);
        chk("flhs_busy", busy, 0);

        // Counter wrap: 17 retirements from reset
        #1;
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
        chk("wrap_start", ops_retired, 0);
        for (int c = 0; c < 19; c++) begin
            if (c < 17) issue(ADD, c + 1, 0, 0, 1'b0, c[TAG_W-1:0]);
            else issue_valid = 1'b0;
            tick;
        end
        chk("wrap_ops_retired", ops_retired, 1);

        // Asynchronous reset mid-stream
        issue(ADD, 32'h1234, 32'h1, 0, 1'b0, 6'd1);
        tick;
        issue(SUB, 32'h55, 32'h1, 0, 1'b0, 6'd2);
        tick;
        chk("mid_busy_before", busy, 1);
        #2;
        nRST = 1'b0;
        #1;
        chk("mid_wb_valid", wb_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_issue_ready", issue_ready, 1);
        chk("mid_aluop", aluop, 0);
        chk("mid_port_a", port_a, 0);
        chk("mid_port_b", port_b, 0);
        chk("mid_wb_result", wb_result, 0);
        chk("mid_wb_flags", wb_flags, 0);
        chk("mid_wb_tag", wb_tag, 0);
        chk("mid_ops_retired", ops_retired, 0);
        issue_valid = 1'b0;
        #1;
        nRST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("mid_discard", wb_valid, 0);
        end
        chk("mid_cnt_after", ops_retired, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fu_alu_ctrl.md
# fu_alu_ctrl

Issue/writeback controller that sits on the driving side of the `fu_alu_if` ALU interface in the tensor-core execute stage. It accepts ALU micro-ops from dispatch over a valid/ready handshake and registers operands into an execute (E) stage that drives `aluop`/`port_a`/`port_b`. It captures `port_output` and the N/V/Z flags into a writeback (W) stage and presents them to the writeback bus over a second valid/ready handshake. It gives full one-op-per-cycle throughput with backpressure, synchronous flush, and a retired-op counter.

## Interface
Parameters:
- `TAG_W`, 6, width of the destination/ROB tag carried with each op
- `CNT_W`, 16, width of the retired-op counter

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge
- `nRST`  in  1  reset, asynchronous and active-low
- `issue_valid`  in  1  dispatch presents an op
- `issue_ready`  out  1  controller can accept an op this cycle
- `issue_aluop`  in  4  ALU operation, passed through opaque
- `issue_a`  in  32  operand A (`word_t`)
- `issue_b`  in  32  register operand B
- `issue_imm`  in  32  immediate operand
- `issue_imm_sel`  in  1  1 selects `issue_imm` as B
- `issue_tag`  in  TAG_W  destination tag
- `flush`  in  1  synchronous squash of all in-flight ops
- `aluop`  out  4  to `fu_alu_if.aluop`
- `port_a`, `port_b`  out  32  to `fu_alu_if`
- `port_output`  in  32  ALU result
- `negative`, `overflow`, `zero`  in  1 each  ALU flags
- `wb_valid`  out  1  result available
- `wb_ready`  in  1  writeback bus accepts
- `wb_result`  out  32  captured result
- `wb_flags`  out  3  {negative, overflow, zero}
- `wb_tag`  out  TAG_W  tag of result
- `busy`  out  1  E or W stage holds a valid op
- `ops_retired`  out  CNT_W  count of completed writeback handshakes

## Operation
- Two registered stages: E (`e_valid`, aluop, A, B, tag) and W (`w_valid`, result, flags, tag).
- The E stage drives `aluop`/`port_a`/`port_b` directly from its registers, so the ALU path is combinational from E into the W capture.
- `w_adv = !w_valid || wb_ready`: W can take a new value or go empty.
- `e_adv = w_adv`: E moves into W when W advances. `issue_ready = !e_valid || e_adv` (combinational, no dependency on `issue_valid`).
- Issue fire = `issue_valid && issue_ready && !flush`. On fire, E loads aluop, A, tag, and B = `issue_imm_sel ? issue_imm : issue_b`. With `e_adv` and no fire, `e_valid` clears.
- On `w_adv`: W loads `port_output`, {`negative`, `overflow`, `zero`} and the E tag. `w_valid` takes `e_valid`.
- Stalled stages (`w_valid && !wb_ready`) hold every field; `wb_*` and `port_*` stay stable while stalled.
- `flush` (synchronous, highest priority):
  - Clears `e_valid` and `w_valid` at the next edge.
  - Drops an issue in the same cycle; dispatch must treat that op as squashed.
  - A writeback handshake completing in the flush cycle still counts as retired.
- `ops_retired` increments on `wb_valid && wb_ready`. It wraps from all-ones to 0 and is not cleared by flush.
- `busy = e_valid || w_valid`.
- Data registers on an invalid stage hold stale values. Only the valid bits matter.

## Timing
- Reset (`nRST` low, asynchronous) drives these to 0:
  - valid bits: `e_valid`, `w_valid`
  - ALU side: `aluop`, `port_a`, `port_b`
  - writeback side: `wb_result`, `wb_flags`, `wb_tag`, `ops_retired`
- So right after reset: `wb_valid`=0, `busy`=0, `issue_ready`=1.
- Reset mid-operation discards in-flight ops with no writeback.
- Latency: op accepted at edge k; drives the ALU during cycle k..k+1; `wb_valid`=1 after edge k+1, i.e. 2 cycles issue-to-writeback.
- Throughput: 1 op/cycle while `wb_ready`=1.
- Backpressure: with `wb_ready`=0 and both stages full, `issue_ready`=0. The first cycle `wb_ready`=1, both stages shift and `issue_ready`=1 in that same cycle.
- Simultaneous writeback accept and issue into a full pipe is legal and loses nothing.

## Test plan
- Reset then single op: ADD, A=0x7FFFFFFF, B=1, tag=5 at edge 0. Required: `wb_valid` after edge 1; `wb_result`=0x80000000, `wb_flags`=3'b110, `wb_tag`=5; `ops_retired`=1 after the handshake.
- Immediate select: `issue_b`=0x10, `issue_imm`=0xFFFFFFFF, `imm_sel`=1, SUB with A=0xFFFFFFFF. Required: `port_b`=0xFFFFFFFF, result 0, `wb_flags`=3'b001.
- Streaming 8 back-to-back ops with `wb_ready`=1. Required: 8 consecutive `wb_valid` cycles, tags in order 0..7, `issue_ready` never low.
- Backpressure: hold `wb_ready`=0 for 4 cycles while issuing.
  - Required: `issue_ready` drops after 2 accepts and `wb_*` stays stable.
  - On release: both ops drain in order, and a third op accepted in the release cycle appears 1 cycle after the second.
- Flush with both stages full and `issue_valid`=1. Required: next cycle `busy`=0, `wb_valid`=0; the flushed-cycle issue never appears; `ops_retired` unchanged.
- Counter wrap with CNT_W=4: 17 retirements. Required: `ops_retired`=1. Also assert `nRST` mid-stream: all outputs 0 asynchronously, before the next edge.
